vector_issue_queue: RTL and testbench

VECTOR_ISSUE_QUEUE -- requirements
Module: vector_issue_queue

---
 rtl/vector_issue_queue.sv | 105 ++++++++++
 tb/tb_vector_issue_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vector_issue_queue.sv
// Issue queue between the scalar core and the vector unit: an in-order FIFO
// that throttles vector memory ops by the number still in flight.
module vector_issue_queue #(
    parameter int DATA_FROM_SCALAR   = 96,
    parameter int DEPTH              = 4,
    parameter int MAX_MEM_OUTSTANDING = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       push_valid,
    input  logic [DATA_FROM_SCALAR-1:0]                push_data,
    output logic                                       push_ready,
    input  logic                                       flush,
    output logic                                       valid_fifo,
    output logic [DATA_FROM_SCALAR-1:0]                instruction,
    input  logic                                       ready,
    input  logic                                       mem_op_done,
    output logic [$clog2(DEPTH):0]                     occupancy,
    output logic [$clog2(MAX_MEM_OUTSTANDING):0]       mem_outstanding
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int MO_W  = $clog2(MAX_MEM_OUTSTANDING) + 1;

    function automatic logic is_mem_op(input logic [DATA_FROM_SCALAR-1:0] pkt);
        return (pkt[6:0] == 7'b0000111) || (pkt[6:0] == 7'b0100111);
    endfunction

    logic [DATA_FROM_SCALAR-1:0] storage_r [DEPTH];
    logic [PTR_W-1:0]            head_r;
    logic [PTR_W-1:0]            tail_r;
    logic [OCC_W-1:0]            occ_r;
    logic [MO_W-1:0]             mem_out_r;

    logic [DATA_FROM_SCALAR-1:0] head_data_s;
    logic                        head_is_mem_s;
    logic                        mem_block_s;
    logic                        push_s;
    logic                        pop_s;
    logic                        mem_pop_s;
    logic                        mem_done_s;

    assign head_data_s   = storage_r[head_r];
    assign head_is_mem_s = is_mem_op(head_data_s);
    // Block uses the registered count, so a same-cycle completion only frees the head next cycle.
    assign mem_block_s   = head_is_mem_s && (mem_out_r == MO_W'(MAX_MEM_OUTSTANDING));

    assign push_ready      = (occ_r < OCC_W'(DEPTH));
    assign valid_fifo      = (occ_r != {OCC_W{1'b0}}) && !mem_block_s && !flush;
    assign instruction     = head_data_s;
    assign occupancy       = occ_r;
    assign mem_outstanding = mem_out_r;

    assign push_s     = push_valid && push_ready && !flush;
    assign pop_s      = valid_fifo && ready;
    assign mem_pop_s  = pop_s && head_is_mem_s;
    assign mem_done_s = mem_op_done && (mem_out_r != {MO_W{1'b0}});

    // Packet storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            storage_r[tail_r] <= push_data;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            occ_r  <= {OCC_W{1'b0}};
        end else if (flush) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            occ_r  <= {OCC_W{1'b0}};
        end else begin
            if (push_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // In-flight memory op counter; survives flush because issued ops still complete.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_out_r <= {MO_W{1'b0}};
        end else begin
            case ({mem_pop_s, mem_done_s})
                2'b10:   mem_out_r <= mem_out_r + MO_W'(1);
                2'b01:   mem_out_r <= mem_out_r - MO_W'(1);
                default: mem_out_r <= mem_out_r;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_issue_queue.sv
// Directed self-checking bench for vector_issue_queue (default parameters).
module tb_vector_issue_queue;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic [95:0] push_data;
    logic        push_ready;
    logic        flush;
    logic        valid_fifo;
    logic [95:0] instruction;
    logic        ready;
    logic        mem_op_done;
    logic [2:0]  occupancy;
    logic [1:0]  mem_outstanding;

    int checks;
    int failures;

    localparam logic [6:0] OP_V  = 7'b1010111;
    localparam logic [6:0] OP_LD = 7'b0000111;
    localparam logic [6:0] OP_ST = 7'b0100111;

    vector_issue_queue dut (
        .clk            (clk),
        .rst            (rst),
        .push_valid     (push_valid),
        .push_data      (push_data),
        .push_ready     (push_ready),
        .flush          (flush),
        .valid_fifo     (valid_fifo),
        .instruction    (instruction),
        .ready          (ready),
        .mem_op_done    (mem_op_done),
        .occupancy      (occupancy),
        .mem_outstanding(mem_outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] pkt(input logic [7:0] id, input logic [6:0] op);
        return {24'hA00000, id, 24'hB00000, id, 17'h0, id, op};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b0;
        push_valid  = 1'b0;
        push_data   = 96'h0;
        flush       = 1'b0;
        ready       = 1'b0;
        mem_op_done = 1'b0;
        #1;
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_mo", mem_outstanding, 2'd0);
        chk("rst_pready", push_ready, 1'b1);
        chk("rst_valid", valid_fifo, 1'b0);
        #11 rst = 1'b1;
        tick();

        // Fill with ready low, then drain in order
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_data  = pkt(8'(8'hA0 + i), OP_V);
            tick();
            if (i == 0) begin
                chk("latency_valid", valid_fifo, 1'b1);
                chk("latency_occ", occupancy, 3'd1);
            end
        end
        chk("full_occ", occupancy, 3'd4);
        chk("full_pready", push_ready, 1'b0);
        push_data = pkt(8'hEE, OP_V);
        tick();
        chk("full_hold_occ", occupancy, 3'd4);
        push_valid = 1'b0;
        ready      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_valid", valid_fifo, 1'b1);
            chk("drain_data", instruction, pkt(8'(8'hA0 + i), OP_V));
            tick();
        end
        chk("drain_occ", occupancy, 3'd0);
        chk("drain_valid_end", valid_fifo, 1'b0);

        // Streaming through the pointer wrap
        for (int k = 0; k <= 10; k++) begin
            push_valid = (k < 10);
            push_data  = pkt(8'(8'h10 + k), OP_V);
            #1;
            if (k > 0) begin
                chk("wrap_data", instruction, pkt(8'(8'h10 + k - 1), OP_V));
                chk("wrap_occ", occupancy, 3'd1);
            end
            tick();
        end
        chk("wrap_occ_end", occupancy, 3'd0);

        // Memory throttle: three loads, limit two in flight
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_data  = pkt(8'(8'h30 + i), OP_LD);
            tick();
        end
        push_valid = 1'b0;
        ready      = 1'b1;
        tick();
        tick();
        chk("thr_valid", valid_fifo, 1'b0);
        chk("thr_occ", occupancy, 3'd1);
        chk("thr_mo", mem_outstanding, 2'd2);
        mem_op_done = 1'b1;
        #1;
        chk("thr_done_same_cycle", valid_fifo, 1'b0);
        tick();
        mem_op_done = 1'b0;
        chk("thr_release_valid", valid_fifo, 1'b1);
        chk("thr_release_data", instruction, pkt(8'h32, OP_LD));
        tick();
        chk("thr_mo_after", mem_outstanding, 2'd2);
        chk("thr_occ_after", occupancy, 3'd0);

        // Simultaneous store issue and completion
        mem_op_done = 1'b1;
        tick();
        mem_op_done = 1'b0;
        chk("sim_mo_1", mem_outstanding, 2'd1);
        ready      = 1'b0;
        push_valid = 1'b1;
        push_data  = pkt(8'h40, OP_ST);
        tick();
        push_valid  = 1'b0;
        ready       = 1'b1;
        mem_op_done = 1'b1;
        tick();
        chk("sim_mo_hold", mem_outstanding, 2'd1);
        chk("sim_occ", occupancy, 3'd0);
        tick();
        chk("sim_mo_0", mem_outstanding, 2'd0);
        tick();
        mem_op_done = 1'b0;
        chk("sim_mo_no_underflow", mem_outstanding, 2'd0);

        // Flush with same-cycle push and pop
        push_valid = 1'b1;
        push_data  = pkt(8'h50, OP_LD);
        tick();
        push_valid = 1'b0;
        tick();
        chk("fl_mo_pre", mem_outstanding, 2'd1);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_valid = 1'b1;
            push_data  = pkt(8'(8'h60 + i), OP_V);
            tick();
        end
        chk("fl_occ_pre", occupancy, 3'd3);
        flush     = 1'b1;
        ready     = 1'b1;
        push_data = pkt(8'h6F, OP_V);
        #1;
        chk("fl_valid_now", valid_fifo, 1'b0);
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        ready      = 1'b0;
        chk("fl_occ", occupancy, 3'd0);
        chk("fl_valid", valid_fifo, 1'b0);
        chk("fl_mo", mem_outstanding, 2'd1);
        push_valid = 1'b1;
        push_data  = pkt(8'h70, OP_V);
        tick();
        push_valid = 1'b0;
        chk("fl_next_data", instruction, pkt(8'h70, OP_V));
        chk("fl_next_occ", occupancy, 3'd1);

        // Asynchronous reset between edges
        push_valid = 1'b1;
        push_data  = pkt(8'h71, OP_V);
        tick();
        push_valid = 1'b0;
        chk("ar_occ_pre", occupancy, 3'd2);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_occ", occupancy, 3'd0);
        chk("ar_mo", mem_outstanding, 2'd0);
        chk("ar_pready", push_ready, 1'b1);
        chk("ar_valid", valid_fifo, 1'b0);
        #1;
        rst        = 1'b1;
        push_valid = 1'b1;
        push_data  = pkt(8'h80, OP_V);
        #1;
        chk("ar_pready_after", push_ready, 1'b1);
        tick();
        push_valid = 1'b0;
        chk("ar_first_occ", occupancy, 3'd1);
        chk("ar_first_data", instruction, pkt(8'h80, OP_V));
        chk("ar_first_valid", valid_fifo, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
